// File: rtl/shift_reg_sequencer_pkg.sv
// Shared types for the shift-register sequencer: command ops, FSM states
// and the datapath step-mode encodings.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        OP_LOAD   = 2'b00,
        OP_SHIFT  = 2'b01,
        OP_ROTATE = 2'b10,
        OP_DSHIFT = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_SHIFT  = 2'b01,
        MODE_ROTATE = 2'b10,
        MODE_DSHIFT = 2'b11
    } mode_e;

endpackage

// File: rtl/shift_reg_sequencer_if.sv
// Command and serial-input handshakes between the host side and the sequencer.
interface shift_reg_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_cnt;
    logic [WIDTH-1:0] cmd_data;
    logic             sin_valid;
    logic             sin_bit;
    logic             sin_ready;

    modport master (
        output cmd_valid, cmd_op, cmd_cnt, cmd_data, sin_valid, sin_bit,
        input  cmd_ready, sin_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_cnt, cmd_data, sin_valid, sin_bit,
        output cmd_ready, sin_ready
    );
endinterface

// File: rtl/shift_reg_sequencer_core.sv
// WIDTH-bit right-shift register: hold / serial shift / rotate / double shift,
// plus parallel load which takes priority over the step mode.
module shift_reg_core
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             Re,
    input  mode_e            mode,
    input  logic             s_in,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] q_d, q_q;

    always_comb begin
        q_d = q_q;
        if (load_en) begin
            q_d = load_data;
        end else begin
            case (mode)
                MODE_SHIFT:  q_d = {s_in, q_q[WIDTH-1:1]};
                MODE_ROTATE: q_d = {q_q[0], q_q[WIDTH-1:1]};
                MODE_DSHIFT: q_d = {s_in, s_in, q_q[WIDTH-1:2]};
                default:     q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!Re) q_q <= '0;
        else     q_q <= q_d;
    end

    assign q = q_q;
endmodule

// File: rtl/shift_reg_sequencer.sv
// Command sequencer for shift_reg_core: IDLE -> RUN -> DONE, one step per clock,
// stalling SHIFT/DSHIFT steps until a serial bit arrives. Optional abort: SHIFT_SEQ_ABORT_EN.
module shift_reg_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                  clk,
    input  logic                  Re,
    shift_reg_sequencer_if.slave  bus,
`ifdef SHIFT_SEQ_ABORT_EN
    input  logic                  abort,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      Q
);
    state_e           state_d, state_q;
    op_e              op_d, op_q;
    logic [CNT_W-1:0] rem_d, rem_q;
    logic [WIDTH-1:0] data_d, data_q;
    mode_e            mode;
    logic             load_en;
    logic             step_ok;

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        rem_d         = rem_q;
        data_d        = data_q;
        mode          = MODE_HOLD;
        load_en       = 1'b0;
        step_ok       = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.sin_ready = 1'b0;
        done          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    op_d    = op_e'(bus.cmd_op);
                    rem_d   = bus.cmd_cnt;
                    data_d  = bus.cmd_data;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
`ifdef SHIFT_SEQ_ABORT_EN
                if (abort) begin
                    rem_d   = '0;
                    state_d = ST_DONE;
                end else
`endif
                if (op_q == OP_LOAD) begin
                    load_en = 1'b1;
                    state_d = ST_DONE;
                end else if (rem_q == '0) begin
                    state_d = ST_DONE;
                end else if (op_q == OP_ROTATE) begin
                    mode    = MODE_ROTATE;
                    step_ok = 1'b1;
                end else begin
                    // SHIFT/DSHIFT: step only on an edge that consumes a bit
                    bus.sin_ready = 1'b1;
                    if (bus.sin_valid) begin
                        mode    = (op_q == OP_DSHIFT) ? MODE_DSHIFT : MODE_SHIFT;
                        step_ok = 1'b1;
                    end
                end
                if (step_ok) begin
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!Re) begin
            state_q <= ST_IDLE;
            op_q    <= OP_LOAD;
            rem_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
        end
    end

    assign busy = (state_q != ST_IDLE);

    shift_reg_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .Re        (Re),
        .mode      (mode),
        .s_in      (bus.sin_bit),
        .load_en   (load_en),
        .load_data (data_q),
        .q         (Q)
    );
endmodule
